ifu_fetch: RTL



---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_fifo.sv | 58 +++++
 rtl/ifu_fetch.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Optional feature macro: IFU_EBREAK_HALT_EN (ebreak predecode halts fetching).
package ifu_pkg;

   localparam int          XLEN_DEF     = 64;
   localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
   localparam logic [31:0] EBREAK_INSN  = 32'h0010_0073;

   // Fetch FSM states; HALT is only reachable with IFU_EBREAK_HALT_EN.
   localparam logic [1:0]  ST_BOOT = 2'd0;
   localparam logic [1:0]  ST_RUN  = 2'd1;
   localparam logic [1:0]  ST_HALT = 2'd2;

   // One buffered fetch result as presented to decode.
   typedef struct packed {
      logic [31:0]         instr;
      logic [XLEN_DEF-1:0] pc;
      logic                fault;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush. Used both as the decode-side output
// buffer and as the tag queue holding PCs of outstanding requests.
// Push when full and pop when empty are ignored; flush wins over both.
module ifu_fifo #(
   parameter int W     = 97,
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_data,
   output logic [W-1:0]             o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;

   logic          w_full;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_full    = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_data    = r_mem[r_rp];
   assign o_count   = r_cnt;

   // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_do_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: issues in-order word fetches under a credit limit,
// buffers responses for decode, and discards stale responses after redirect.
// Optional feature macro: IFU_EBREAK_HALT_EN (stop fetching after an ebreak).
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int              XLEN       = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_rsp_valid,
   input  logic [31:0]     i_imem_rsp_data,
   input  logic            i_imem_rsp_err,
   output logic            o_id_valid,
   input  logic            i_id_ready,
   output logic [31:0]     o_id_instr,
   output logic [XLEN-1:0] o_id_pc,
   output logic            o_id_fault,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = 32 + XLEN + 1;

   logic [1:0]      r_state;
   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   r_drop;

   logic [CW-1:0]   w_out;
   logic [CW-1:0]   w_obuf_cnt;
   logic            w_obuf_empty;
   logic            w_tag_empty;
   logic [XLEN-1:0] w_tag_pc;
   logic [EW-1:0]   w_head;
   logic [CW+1:0]   w_used;
   logic            w_credit;
   logic            w_req_hs;
   logic            w_id_hs;
   logic            w_rsp_stale;
   logic            w_push;
   logic            w_halt_go;
   logic            w_flush_tags;
   logic [CW:0]     w_drop_sum;

   // Everything in flight or buffered must fit in the output buffer, so a
   // response always has a slot waiting for it.
   assign w_used   = {2'b00, w_out} + {2'b00, r_drop} + {2'b00, w_obuf_cnt};
   assign w_credit = (w_used < (CW+2)'(FIFO_DEPTH));

   assign o_imem_req_valid = (r_state == ST_RUN) & w_credit;
   assign o_imem_req_addr  = r_pc;

   assign w_req_hs    = o_imem_req_valid & i_imem_req_ready;
   assign w_id_hs     = o_id_valid & i_id_ready;
   assign w_rsp_stale = i_imem_rsp_valid & ((r_drop != '0) | i_redirect_valid);
   assign w_push      = i_imem_rsp_valid & ~w_rsp_stale;

`ifdef IFU_EBREAK_HALT_EN
   assign w_halt_go = w_push & (i_imem_rsp_data == EBREAK_INSN);
`else
   assign w_halt_go = 1'b0;
`endif

   // Redirect and halt both turn every outstanding request into a drop.
   assign w_flush_tags = i_redirect_valid | w_halt_go;

   // Drop count after a flush: all outstanding plus this cycle's handshake,
   // less the response consumed this cycle (stale or the halting push).
   assign w_drop_sum = {1'b0, r_drop} + {1'b0, w_out}
                     + (CW+1)'(w_req_hs) - (CW+1)'(i_imem_rsp_valid);

   // PCs of outstanding requests, oldest at the head; its count is the
   // outstanding-request count.
   ifu_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (w_flush_tags),
      .i_push  (w_req_hs),
      .i_pop   (w_push),
      .i_data  (r_pc),
      .o_data  (w_tag_pc),
      .o_count (w_out),
      .o_empty (w_tag_empty)
   );

   // Output buffer of {instr, pc, fault} for decode.
   ifu_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_obuf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_redirect_valid),
      .i_push  (w_push),
      .i_pop   (w_id_hs),
      .i_data  ({i_imem_rsp_data, w_tag_pc, i_imem_rsp_err}),
      .o_data  (w_head),
      .o_count (w_obuf_cnt),
      .o_empty (w_obuf_empty)
   );

   assign o_id_valid = ~w_obuf_empty;
   assign o_id_instr = w_head[EW-1 -: 32];
   assign o_id_pc    = w_head[XLEN:1];
   assign o_id_fault = w_head[0];

   // Fetch FSM: one idle boot cycle, then run (optionally halt on ebreak).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_BOOT;
      end else begin
         case (r_state)
            ST_BOOT: r_state <= ST_RUN;
`ifdef IFU_EBREAK_HALT_EN
            ST_RUN:  if (w_halt_go) r_state <= ST_HALT;
            ST_HALT: if (i_redirect_valid) r_state <= ST_RUN;
`endif
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // Fetch PC: redirect target (word aligned) wins over sequential advance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc <= RESET_PC;
      end else if (i_redirect_valid) begin
         r_pc <= i_redirect_pc & ~XLEN'(3);
      end else if (w_req_hs) begin
         r_pc <= r_pc + XLEN'(4);
      end
   end

   // Count of in-flight responses that belong to discarded fetch streams.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_drop <= '0;
      end else if (w_flush_tags) begin
         r_drop <= w_drop_sum[CW-1:0];
      end else if (w_rsp_stale) begin
         r_drop <= r_drop - 1'b1;
      end
   end

   // A response with nothing in flight means memory broke the protocol;
   // a live response must also have a tag to pair with.
   a_rsp_order: assert property (@(posedge i_clk) disable iff (i_rst)
      i_imem_rsp_valid |-> ((w_out != '0) || (r_drop != '0)));
   a_rsp_tag: assert property (@(posedge i_clk) disable iff (i_rst)
      w_push |-> !w_tag_empty);

endmodule
